pool_cmp_win: RTL and testbench

//  Per-channel temporal pooling over a window of WIN consecutive accepted beats, for DN channels in parallel.

---
 rtl/pool_cmp_win_if.sv | 11 +
 rtl/pool_cmp_win.sv | 129 ++++++++++++
 tb/tb_pool_cmp_win.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pool_cmp_win_if.sv
// Valid/ready stream bundle used on both sides of the pooling block.
interface pool_cmp_win_if #(
    parameter int unsigned W = 48
) ();
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/pool_cmp_win.sv
// Per-channel temporal max/min/avg pooling over WIN accepted beats, DN channels wide,
// with valid/ready backpressure and a one-entry registered output.
module pool_cmp_win #(
    parameter int unsigned DW     = 8,
    parameter int unsigned DN     = 6,
    parameter int unsigned WIN    = 2,
    parameter int unsigned SIGNED = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      mode,
    input  logic            clear,
    pool_cmp_win_if.slave   m,
    pool_cmp_win_if.master  s,
    output logic            busy
);
    localparam int unsigned SH  = $clog2(WIN);
    localparam int unsigned CW  = SH;
    localparam int unsigned AW  = DW + SH;
    localparam int unsigned BW  = DN * DW;
    localparam int unsigned ABW = DN * AW;

    localparam logic [1:0] MODE_MAX = 2'b00;
    localparam logic [1:0] MODE_MIN = 2'b01;
    localparam logic [1:0] MODE_AVG = 2'b10;

    logic [CW-1:0]  cnt_q, cnt_d;
    logic [ABW-1:0] acc_q, acc_d;
    logic [1:0]     mode_q, mode_d;
    logic           s_valid_q, s_valid_d;
    logic [BW-1:0]  s_data_q, s_data_d;

    logic [ABW-1:0] ext_c;
    logic [ABW-1:0] op_c;
    logic [BW-1:0]  res_c;
    logic           m_ready_c;
    logic           accept_c;

    // Per-channel datapath: extend incoming element, combine with acc, form the result.
    for (genvar i = 0; i < DN; i++) begin : g_ch
        logic [AW-1:0] a_c, x_c, sum_c, op_ch_c;
        logic [DW-1:0] shr_c;
        logic          lt_c, gt_c;

        assign a_c   = acc_q[i*AW +: AW];
        assign sum_c = a_c + x_c;

        if (SIGNED != 0) begin : g_s
            assign x_c   = {{SH{m.data[i*DW+DW-1]}}, m.data[i*DW +: DW]};
            assign lt_c  = $signed(x_c) < $signed(a_c);
            assign gt_c  = $signed(x_c) > $signed(a_c);
            assign shr_c = DW'($signed(sum_c) >>> SH);
        end else begin : g_u
            assign x_c   = {{SH{1'b0}}, m.data[i*DW +: DW]};
            assign lt_c  = x_c < a_c;
            assign gt_c  = x_c > a_c;
            assign shr_c = DW'(sum_c >> SH);
        end

        // Ties keep the accumulated value; reserved mode falls through to max.
        always_comb begin
            op_ch_c = gt_c ? x_c : a_c;
            case (mode_q)
                MODE_MIN: op_ch_c = lt_c ? x_c : a_c;
                MODE_AVG: op_ch_c = sum_c;
                default:  op_ch_c = gt_c ? x_c : a_c;
            endcase
        end

        assign ext_c[i*AW +: AW] = x_c;
        assign op_c[i*AW +: AW]  = op_ch_c;
        assign res_c[i*DW +: DW] = (mode_q == MODE_AVG) ? shr_c : op_ch_c[DW-1:0];
    end

    assign m_ready_c = !(s_valid_q && !s.ready);
    assign accept_c  = m.valid && m_ready_c;

    // Window sequencing and output register update.
    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mode_d    = mode_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;

        if (s_valid_q && s.ready) begin
            s_valid_d = 1'b0;
        end

        if (clear) begin
            cnt_d = '0;
        end else if (accept_c) begin
            if (cnt_q == '0) begin
                mode_d = mode;
                acc_d  = ext_c;
                cnt_d  = CW'(1);
            end else if (cnt_q == CW'(WIN - 1)) begin
                s_data_d  = res_c;
                s_valid_d = 1'b1;
                cnt_d     = '0;
            end else begin
                acc_d = op_c;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            mode_q    <= MODE_MAX;
            s_valid_q <= 1'b0;
            s_data_q  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mode_q    <= mode_d;
            s_valid_q <= s_valid_d;
            s_data_q  <= s_data_d;
        end
    end

    assign m.ready = m_ready_c;
    assign s.valid = s_valid_q;
    assign s.data  = s_data_q;
    assign busy    = (cnt_q != '0);

endmodule

// File: tb/tb_pool_cmp_win.sv
// Bench for pool_cmp_win: WIN=2 unsigned and WIN=4 signed instances against a window-level model.
module tb_pool_cmp_win;
    logic       clk = 1'b0;
    logic       a_rst, b_rst;
    logic [1:0] a_mode, b_mode;
    logic       a_clear, b_clear;
    logic       a_busy, b_busy;
    int         checks;
    int         errors;

    pool_cmp_win_if #(.W(48)) a_m ();
    pool_cmp_win_if #(.W(48)) a_s ();
    pool_cmp_win_if #(.W(48)) b_m ();
    pool_cmp_win_if #(.W(48)) b_s ();

    pool_cmp_win #(.DW(8), .DN(6), .WIN(2), .SIGNED(0)) dut_a (
        .clk(clk), .rst(a_rst), .mode(a_mode), .clear(a_clear),
        .m(a_m), .s(a_s), .busy(a_busy)
    );

    pool_cmp_win #(.DW(8), .DN(6), .WIN(4), .SIGNED(1)) dut_b (
        .clk(clk), .rst(b_rst), .mode(b_mode), .clear(b_clear),
        .m(b_m), .s(b_s), .busy(b_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] rnd48();
        return {16'($urandom), 32'($urandom)};
    endfunction

    // Pool a whole window from the element values: max/min/floor-average per channel.
    function automatic logic [47:0] model_pool(input bit sgn, input logic [1:0] md, input logic [47:0] bq[$]);
        logic [47:0] r;
        r = '0;
        for (int c = 0; c < 6; c++) begin
            int mx, mn, sum, v, res, n;
            logic [7:0] e;
            n = bq.size();
            sum = 0; mx = 0; mn = 0;
            for (int k = 0; k < n; k++) begin
                e = bq[k][c*8 +: 8];
                if (sgn) v = int'($signed(e));
                else     v = int'(e);
                if (k == 0) begin mx = v; mn = v; end
                else begin
                    if (v > mx) mx = v;
                    if (v < mn) mn = v;
                end
                sum += v;
            end
            if (md == 2'b01)      res = mn;
            else if (md == 2'b10) res = (sum >= 0) ? sum / n : -((-sum + n - 1) / n);
            else                  res = mx;
            r[c*8 +: 8] = 8'(res);
        end
        return r;
    endfunction

    task automatic a_cycle(input logic v, input logic [47:0] d, input logic sr);
        a_m.valid = v; a_m.data = d; a_s.ready = sr;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic b_cycle(input logic v, input logic [47:0] d, input logic sr, input logic clr);
        b_m.valid = v; b_m.data = d; b_s.ready = sr; b_clear = clr;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset();
        a_rst = 1'b1; b_rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (a_s.valid !== 1'b0) begin errors++; $display("FAIL reset_a_valid: got %b exp 0", a_s.valid); end
        checks++; if (a_s.data !== 48'h0) begin errors++; $display("FAIL reset_a_data: got %h exp 0", a_s.data); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_a_busy: got %b exp 0", a_busy); end
        checks++; if (a_m.ready !== 1'b1) begin errors++; $display("FAIL reset_a_mready: got %b exp 1", a_m.ready); end
        checks++; if (b_s.valid !== 1'b0) begin errors++; $display("FAIL reset_b_valid: got %b exp 0", b_s.valid); end
        checks++; if (b_s.data !== 48'h0) begin errors++; $display("FAIL reset_b_data: got %h exp 0", b_s.data); end
        checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL reset_b_busy: got %b exp 0", b_busy); end
        a_rst = 1'b0; b_rst = 1'b0;
    endtask

    task automatic test_max_basic();
        logic [47:0] b1, b2, e;
        logic [47:0] w[$];
        a_mode = 2'b00;
        b1 = rnd48(); b1[7:0] = 8'h10;
        b2 = rnd48(); b2[7:0] = 8'hF0;
        w.push_back(b1); w.push_back(b2);
        e = model_pool(1'b0, 2'b00, w);
        a_cycle(1'b1, b1, 1'b1);
        checks++; if (a_s.valid !== 1'b0) begin errors++; $display("FAIL max_early_valid: got %b exp 0", a_s.valid); end
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL max_busy: got %b exp 1", a_busy); end
        a_cycle(1'b1, b2, 1'b1);
        checks++; if (a_s.valid !== 1'b1) begin errors++; $display("FAIL max_valid: got %b exp 1", a_s.valid); end
        checks++; if (a_s.data !== e) begin errors++; $display("FAIL max_data: got %h exp %h", a_s.data, e); end
        checks++; if (a_s.data[7:0] !== 8'hF0) begin errors++; $display("FAIL max_ch0: got %h exp f0", a_s.data[7:0]); end
        a_cycle(1'b0, 48'h0, 1'b1);
        checks++; if (a_s.valid !== 1'b0) begin errors++; $display("FAIL max_drain: got %b exp 0", a_s.valid); end
    endtask

    task automatic test_signed();
        int         c0[3][4];
        logic [1:0] md[3];
        logic [7:0] e0[3];
        logic [47:0] d, e;
        logic [47:0] w[$];
        c0 = '{'{5, -3, 7, -8}, '{5, -3, 7, -8}, '{-1, -1, -1, -2}};
        md = '{2'b01, 2'b10, 2'b10};
        e0 = '{8'hF8, 8'h00, 8'hFE};
        for (int t = 0; t < 3; t++) begin
            w.delete();
            b_mode = md[t];
            for (int k = 0; k < 4; k++) begin
                d = rnd48(); d[7:0] = 8'(c0[t][k]);
                w.push_back(d);
                b_cycle(1'b1, d, 1'b1, 1'b0);
            end
            e = model_pool(1'b1, md[t], w);
            checks++; if (b_s.valid !== 1'b1) begin errors++; $display("FAIL signed_valid[%0d]: got %b exp 1", t, b_s.valid); end
            checks++; if (b_s.data !== e) begin errors++; $display("FAIL signed_data[%0d]: got %h exp %h", t, b_s.data, e); end
            checks++; if (b_s.data[7:0] !== e0[t]) begin errors++; $display("FAIL signed_ch0[%0d]: got %h exp %h", t, b_s.data[7:0], e0[t]); end
            b_cycle(1'b0, 48'h0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_gap();
        logic [47:0] b1, b2, e;
        logic [47:0] w[$];
        a_mode = 2'b00;
        b1 = rnd48(); b2 = rnd48();
        w.push_back(b1); w.push_back(b2);
        e = model_pool(1'b0, 2'b00, w);
        a_cycle(1'b1, b1, 1'b1);
        for (int g = 0; g < 3; g++) begin
            a_cycle(1'b0, rnd48(), 1'b1);
            checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL gap_busy[%0d]: got %b exp 1", g, a_busy); end
            checks++; if (a_s.valid !== 1'b0) begin errors++; $display("FAIL gap_valid[%0d]: got %b exp 0", g, a_s.valid); end
        end
        a_cycle(1'b1, b2, 1'b1);
        checks++; if (a_s.valid !== 1'b1 || a_s.data !== e) begin errors++; $display("FAIL gap_result: got v=%b %h exp v=1 %h", a_s.valid, a_s.data, e); end
        a_cycle(1'b0, 48'h0, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [47:0] b1, b2, e;
        logic [47:0] w[$];
        a_mode = 2'b01;
        b1 = rnd48(); b2 = rnd48();
        w.push_back(b1); w.push_back(b2);
        e = model_pool(1'b0, 2'b01, w);
        a_cycle(1'b1, b1, 1'b0);
        a_cycle(1'b1, b2, 1'b0);
        for (int h = 0; h < 3; h++) begin
            a_cycle(1'b1, rnd48(), 1'b0);
            checks++; if (a_m.ready !== 1'b0) begin errors++; $display("FAIL bp_mready[%0d]: got %b exp 0", h, a_m.ready); end
            checks++; if (a_s.valid !== 1'b1 || a_s.data !== e) begin errors++; $display("FAIL bp_hold[%0d]: got v=%b %h exp v=1 %h", h, a_s.valid, a_s.data, e); end
            checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL bp_busy[%0d]: got %b exp 0", h, a_busy); end
        end
        a_cycle(1'b0, 48'h0, 1'b1);
        checks++; if (a_s.valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b exp 0", a_s.valid); end
    endtask

    task automatic test_back_to_back();
        logic [47:0] b1, b2, e;
        logic [47:0] w[$];
        for (int t = 0; t < 4; t++) begin
            a_mode = 2'(t);
            b1 = rnd48(); b2 = rnd48();
            w.delete(); w.push_back(b1); w.push_back(b2);
            e = model_pool(1'b0, 2'(t), w);
            a_cycle(1'b1, b1, 1'b1);
            checks++; if (a_s.valid !== 1'b0 || a_busy !== 1'b1) begin errors++; $display("FAIL b2b_mid[%0d]: got v=%b busy=%b exp v=0 busy=1", t, a_s.valid, a_busy); end
            a_cycle(1'b1, b2, 1'b1);
            checks++; if (a_s.valid !== 1'b1 || a_s.data !== e) begin errors++; $display("FAIL b2b_result[%0d]: got v=%b %h exp v=1 %h", t, a_s.valid, a_s.data, e); end
        end
        a_cycle(1'b0, 48'h0, 1'b1);
    endtask

    task automatic test_clear();
        logic [47:0] d, e;
        logic [47:0] w[$];
        b_mode = 2'b00;
        b_cycle(1'b1, rnd48(), 1'b1, 1'b0);
        checks++; if (b_busy !== 1'b1) begin errors++; $display("FAIL clr_pre_busy: got %b exp 1", b_busy); end
        b_m.valid = 1'b1; b_m.data = 48'hFFFF_FFFF_FFFF; b_s.ready = 1'b1; b_clear = 1'b1;
        #1;
        checks++; if (b_m.ready !== 1'b1) begin errors++; $display("FAIL clr_ack: got %b exp 1", b_m.ready); end
        @(posedge clk); @(negedge clk);
        checks++; if (b_busy !== 1'b0 || b_s.valid !== 1'b0) begin errors++; $display("FAIL clr_state: got busy=%b v=%b exp 0 0", b_busy, b_s.valid); end
        for (int k = 0; k < 4; k++) begin
            d = rnd48(); w.push_back(d);
            b_cycle(1'b1, d, 1'b1, 1'b0);
            if (k < 3) begin
                checks++; if (b_s.valid !== 1'b0) begin errors++; $display("FAIL clr_early[%0d]: got %b exp 0", k, b_s.valid); end
            end
        end
        e = model_pool(1'b1, 2'b00, w);
        checks++; if (b_s.valid !== 1'b1 || b_s.data !== e) begin errors++; $display("FAIL clr_result: got v=%b %h exp v=1 %h", b_s.valid, b_s.data, e); end
        b_cycle(1'b0, 48'h0, 1'b1, 1'b0);
        checks++; if (b_s.valid !== 1'b0) begin errors++; $display("FAIL clr_single: got %b exp 0", b_s.valid); end
    endtask

    task automatic test_mode_switch();
        logic [47:0] d, e;
        logic [47:0] w[$];
        for (int k = 0; k < 4; k++) begin
            b_mode = (k == 0) ? 2'b01 : 2'b10;
            d = rnd48(); w.push_back(d);
            b_cycle(1'b1, d, 1'b1, 1'b0);
        end
        e = model_pool(1'b1, 2'b01, w);
        checks++; if (b_s.valid !== 1'b1 || b_s.data !== e) begin errors++; $display("FAIL mode_latch: got v=%b %h exp v=1 %h", b_s.valid, b_s.data, e); end
        b_cycle(1'b0, 48'h0, 1'b1, 1'b0);
    endtask

    task automatic test_rst_mid();
        logic [47:0] b4, b5, e;
        logic [47:0] w[$];
        a_mode = 2'b00;
        a_cycle(1'b1, rnd48() | 48'h1, 1'b0);
        a_cycle(1'b1, rnd48() | 48'h1, 1'b0);
        checks++; if (a_s.valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %b exp 1", a_s.valid); end
        a_rst = 1'b1;
        a_cycle(1'b0, 48'h0, 1'b0);
        a_rst = 1'b0;
        checks++; if (a_s.valid !== 1'b0 || a_s.data !== 48'h0 || a_busy !== 1'b0) begin errors++; $display("FAIL rst_pending: got v=%b %h busy=%b exp 0 0 0", a_s.valid, a_s.data, a_busy); end
        a_cycle(1'b1, rnd48(), 1'b1);
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL rst_partial_busy: got %b exp 1", a_busy); end
        a_rst = 1'b1;
        a_cycle(1'b0, 48'h0, 1'b1);
        a_rst = 1'b0;
        checks++; if (a_busy !== 1'b0 || a_s.valid !== 1'b0) begin errors++; $display("FAIL rst_partial: got busy=%b v=%b exp 0 0", a_busy, a_s.valid); end
        a_mode = 2'b01;
        b4 = rnd48(); b5 = rnd48();
        w.push_back(b4); w.push_back(b5);
        e = model_pool(1'b0, 2'b01, w);
        a_cycle(1'b1, b4, 1'b1);
        a_cycle(1'b1, b5, 1'b1);
        checks++; if (a_s.valid !== 1'b1 || a_s.data !== e) begin errors++; $display("FAIL rst_after: got v=%b %h exp v=1 %h", a_s.valid, a_s.data, e); end
        a_cycle(1'b0, 48'h0, 1'b1);
    endtask

    task automatic test_random();
        logic [47:0] win_q[$];
        logic [47:0] exp_q[$];
        logic [1:0]  lat;
        logic        er, acc, out;
        int          acc_n, cyc;
        acc_n = 0; cyc = 0; lat = 2'b00;
        while (acc_n < 120 && cyc < 3000) begin
            b_m.valid = ($urandom_range(0, 3) != 0);
            b_m.data  = rnd48();
            b_s.ready = ($urandom_range(0, 2) != 0);
            b_mode    = 2'($urandom_range(0, 3));
            b_clear   = ($urandom_range(0, 19) == 0);
            #1;
            er = (exp_q.size() != 0);
            checks++; if (b_s.valid !== er) begin errors++; $display("FAIL rnd_valid@%0d: got %b exp %b", cyc, b_s.valid, er); end
            er = !((exp_q.size() != 0) && !b_s.ready);
            checks++; if (b_m.ready !== er) begin errors++; $display("FAIL rnd_mready@%0d: got %b exp %b", cyc, b_m.ready, er); end
            er = (win_q.size() != 0);
            checks++; if (b_busy !== er) begin errors++; $display("FAIL rnd_busy@%0d: got %b exp %b", cyc, b_busy, er); end
            out = b_s.valid && b_s.ready;
            acc = b_m.valid && b_m.ready;
            if (out && exp_q.size() != 0) begin
                checks++; if (b_s.data !== exp_q[0]) begin errors++; $display("FAIL rnd_data@%0d: got %h exp %h", cyc, b_s.data, exp_q[0]); end
                void'(exp_q.pop_front());
            end
            if (b_clear) begin
                win_q.delete();
            end else if (acc) begin
                if (win_q.size() == 0) lat = b_mode;
                win_q.push_back(b_m.data);
                acc_n++;
                if (win_q.size() == 4) begin
                    exp_q.push_back(model_pool(1'b1, lat, win_q));
                    win_q.delete();
                end
            end
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        checks++; if (acc_n < 120) begin errors++; $display("FAIL rnd_budget: got %0d beats exp 120", acc_n); end
        b_m.valid = 1'b0; b_s.ready = 1'b1; b_clear = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (b_s.valid === 1'b1 && exp_q.size() != 0) begin
                checks++; if (b_s.data !== exp_q[0]) begin errors++; $display("FAIL rnd_drain_data: got %h exp %h", b_s.data, exp_q[0]); end
                void'(exp_q.pop_front());
            end
            @(posedge clk); @(negedge clk);
        end
        checks++; if (exp_q.size() != 0 || b_s.valid !== 1'b0) begin errors++; $display("FAIL rnd_drain: got %0d outstanding v=%b exp 0 0", exp_q.size(), b_s.valid); end
    endtask

    initial begin
        checks = 0; errors = 0;
        a_rst = 1'b1; b_rst = 1'b1;
        a_mode = 2'b00; b_mode = 2'b00;
        a_clear = 1'b0; b_clear = 1'b0;
        a_m.valid = 1'b0; a_m.data = '0; a_s.ready = 1'b1;
        b_m.valid = 1'b0; b_m.data = '0; b_s.ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_max_basic();
        test_signed();
        test_gap();
        test_backpressure();
        test_back_to_back();
        test_clear();
        test_mode_switch();
        test_rst_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
